avalon_pio_in_edge: RTL

- Avalon-MM slave input PIO: the receive-side counterpart to the team's 8-bit output PIO on the same slave port conventions.
- Samples an asynchronous external bus `in_port` through a synchronizer and captures edges per bit into sticky bits.
- Raises a level interrupt to the Nios/bus master through a per-bit mask.
- Sits on the system interconnect with the same 2-bit word address, chipselect and zero-wait-state read as the output PIO.

---
 rtl/avalon_pio_in_edge.sv | 112 +++++++++++
 1 files changed

// File: rtl/avalon_pio_in_edge.sv
// Avalon-MM input PIO: synchronizes an async input bus, captures per-bit edges
// into sticky write-1-to-clear bits and raises a masked level interrupt.
module avalon_pio_in_edge #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned EDGE_TYPE   = 0,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int unsigned PRIME_MAX = SYNC_STAGES + 1;
    localparam int unsigned PRIME_W   = $clog2(PRIME_MAX + 1);

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_CAP  = 2'd3;

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  data_sync;
    logic [WIDTH-1:0]                  data_d1_q;
    logic [PRIME_W-1:0]                prime_q, prime_d;
    logic                              primed;
    logic [WIDTH-1:0]                  edge_det;
    logic [WIDTH-1:0]                  edge_set;
    logic [WIDTH-1:0]                  cap_q, cap_d;
    logic [WIDTH-1:0]                  mask_q, mask_d;
    logic [WIDTH-1:0]                  clr_bits;
    logic                              irq_q, irq_d;
    logic                              wr_en;
    logic                              wdata_unused;

    // Upper writedata bits are intentionally ignored for narrow builds
    assign wdata_unused = ^writedata;

    assign data_sync = sync_q[SYNC_STAGES-1];
    assign wr_en     = chipselect && !write_n;
    assign primed    = (prime_q == PRIME_W'(PRIME_MAX));

    // Synchronizer chain, delay register and prime counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q    <= '0;
            data_d1_q <= '0;
            prime_q   <= '0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], in_port};
            data_d1_q <= data_sync;
            prime_q   <= prime_d;
        end
    end

    always_comb begin
        prime_d  = primed ? prime_q : prime_q + PRIME_W'(1);
        edge_det = '0;
        case (EDGE_TYPE)
            0:       edge_det = data_sync & ~data_d1_q;
            1:       edge_det = ~data_sync & data_d1_q;
            default: edge_det = data_sync ^ data_d1_q;
        endcase
        // Gate detection until the chain holds real samples, so static-high
        // inputs at reset don't look like edges
        edge_set = primed ? edge_det : '0;
    end

    // Register updates: an edge wins over a same-cycle clear so no event is lost
    always_comb begin
        clr_bits = '0;
        mask_d   = mask_q;
        if (wr_en && (address == ADDR_CAP)) begin
            clr_bits = writedata[WIDTH-1:0];
        end
        if (wr_en && (address == ADDR_MASK)) begin
            mask_d = writedata[WIDTH-1:0];
        end
        cap_d = (cap_q & ~clr_bits) | edge_set;
        irq_d = |(cap_q & mask_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cap_q  <= '0;
            mask_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            cap_q  <= cap_d;
            mask_q <= mask_d;
            irq_q  <= irq_d;
        end
    end

    assign irq = irq_q;

    // Zero-wait-state read mux
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA: readdata = 32'(data_sync);
            ADDR_MASK: readdata = 32'(mask_q);
            ADDR_CAP:  readdata = 32'(cap_q);
            default:   readdata = '0;
        endcase
    end

endmodule
